// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronized switches, debounced push-buttons with
// sticky press flags (W1C) and an 8-bit press counter, read back with 1-cycle latency.
module io_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] readdata_io,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY
);

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_SWITCH,
        SEL_KEYLEVEL,
        SEL_KEYEDGE,
        SEL_KEYCOUNT
    } reg_sel_t;

    logic [9:0]       sw_meta, sw_sync;
    logic [3:0]       key_meta, key_sync;
    logic [3:0]       key_stable, stable_next;
    logic [3:0][15:0] deb_cnt, deb_cnt_next;
    logic [3:0]       press;
    logic [2:0]       press_cnt;
    logic [3:0]       key_edge, edge_next;
    logic [7:0]       key_count, count_next;
    logic [31:0]      rd_next;
    reg_sel_t         sel;

    // Address bits outside the decode and data bits above the key lanes are don't-care.
    logic unused_bits;
    assign unused_bits = ^{addr[31:9], addr[7:6], addr[1:0], writedata[31:4]};

    always_comb begin
        sel = SEL_NONE;
        if (addr[8]) begin
            if (addr[2])      sel = SEL_SWITCH;
            else if (addr[3]) sel = SEL_KEYLEVEL;
            else if (addr[4]) sel = SEL_KEYEDGE;
            else if (addr[5]) sel = SEL_KEYCOUNT;
        end
    end

    always_comb begin
        stable_next  = key_stable;
        deb_cnt_next = '0;
        press        = '0;
        press_cnt    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (key_sync[i] != key_stable[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    stable_next[i] = key_sync[i];
                    press[i]       = ~key_sync[i];
                end else begin
                    deb_cnt_next[i] = deb_cnt[i] + 16'd1;
                end
            end
            press_cnt = press_cnt + 3'(press[i]);
        end
    end

    // A press landing on the same edge as a W1C keeps its flag set.
    always_comb begin
        edge_next  = key_edge;
        count_next = key_count + {5'b0, press_cnt};
        if (memwrite && sel == SEL_KEYEDGE)
            edge_next = key_edge & ~writedata[3:0];
        if (memwrite && sel == SEL_KEYCOUNT)
            count_next = {5'b0, press_cnt};
        edge_next = edge_next | press;
    end

    always_comb begin
        rd_next = '0;
        case (sel)
            SEL_SWITCH:   rd_next = {22'b0, sw_sync};
            SEL_KEYLEVEL: rd_next = {28'b0, ~key_stable};
            SEL_KEYEDGE:  rd_next = {28'b0, key_edge};
            SEL_KEYCOUNT: rd_next = {24'b0, key_count};
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            key_meta    <= '1;
            key_sync    <= '1;
            key_stable  <= '1;
            deb_cnt     <= '0;
            key_edge    <= '0;
            key_count   <= '0;
            readdata_io <= '0;
        end else begin
            sw_meta     <= SW;
            sw_sync     <= sw_meta;
            key_meta    <= KEY;
            key_sync    <= key_meta;
            key_stable  <= stable_next;
            deb_cnt     <= deb_cnt_next;
            key_edge    <= edge_next;
            key_count   <= count_next;
            readdata_io <= rd_next;
        end
    end

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port: reset, switch read, debounce, W1C/collision,
// counter wrap and address decode, against hand-computed expectations.
module tb_io_input_port;

    localparam int unsigned DEB  = 16;
    localparam int unsigned HOLD = DEB + 6;

    localparam logic [31:0] A_SW    = 32'h104;
    localparam logic [31:0] A_LEVEL = 32'h108;
    localparam logic [31:0] A_EDGE  = 32'h110;
    localparam logic [31:0] A_COUNT = 32'h120;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata_io;
    logic [9:0]  SW;
    logic [3:0]  KEY;

    int n_checks = 0;
    int n_errors = 0;

    io_input_port #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .memwrite   (memwrite),
        .writedata  (writedata),
        .readdata_io(readdata_io),
        .SW         (SW),
        .KEY        (KEY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        tick(1);
        check(tag, readdata_io, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        tick(1);
        memwrite  = 1'b0;
        writedata = '0;
    endtask

    task automatic press(input logic [3:0] mask);
        KEY = KEY & ~mask;
        tick(HOLD);
        KEY = KEY | mask;
        tick(HOLD);
    endtask

    initial begin
        reset     = 1'b0;
        addr      = '0;
        memwrite  = 1'b0;
        writedata = '0;
        SW        = '0;
        KEY       = 4'hF;

        // Reset state
        tick(2);
        rd("rst_count_in_reset", A_COUNT, 32'h0);
        rd("rst_level_in_reset", A_LEVEL, 32'h0);
        reset = 1'b1;
        rd("rst_level", A_LEVEL, 32'h0);
        rd("rst_edge", A_EDGE, 32'h0);
        rd("rst_count", A_COUNT, 32'h0);

        // Switch read and decode
        SW = 10'h2A5;
        tick(3);
        rd("sw_read", A_SW, 32'h2A5);
        rd("sw_not_io", 32'h004, 32'h0);
        rd("sw_multi_sel", 32'h10C, 32'h2A5);
        rd("unmapped_io", 32'h100, 32'h0);
        rd("edge_multi_sel", 32'h130, 32'h0);

        // Debounce: stable changes on edge 18 after KEY falls
        KEY = 4'hD;
        tick(16);
        rd("deb_level_early", A_LEVEL, 32'h0);
        tick(2);
        rd("deb_level", A_LEVEL, 32'h2);
        rd("deb_edge", A_EDGE, 32'h2);
        rd("deb_count", A_COUNT, 32'h1);
        KEY = 4'hF;
        tick(HOLD);
        rd("deb_release_count", A_COUNT, 32'h1);
        wr(A_EDGE, 32'h2);

        // Short glitch must not be accepted
        KEY = 4'hD;
        tick(10);
        KEY = 4'hF;
        tick(HOLD);
        rd("glitch_level", A_LEVEL, 32'h0);
        rd("glitch_edge", A_EDGE, 32'h0);
        rd("glitch_count", A_COUNT, 32'h1);
        wr(A_COUNT, 32'h0);
        rd("count_clear", A_COUNT, 32'h0);

        // Simultaneous press, W1C, collision
        press(4'hF);
        rd("all_edge", A_EDGE, 32'hF);
        rd("all_count", A_COUNT, 32'h4);
        wr(A_EDGE, 32'h5);
        rd("w1c_5", A_EDGE, 32'hA);
        wr(A_EDGE, 32'h2);
        rd("w1c_2", A_EDGE, 32'h8);
        KEY = 4'hD;
        tick(17);
        addr      = A_EDGE;
        writedata = 32'h2;
        memwrite  = 1'b1;
        tick(1);
        memwrite  = 1'b0;
        writedata = '0;
        rd("collision_set_wins", A_EDGE, 32'hA);
        KEY = 4'hF;
        tick(HOLD);
        rd("collision_count", A_COUNT, 32'h5);

        // Writes to read-only / non-IO / unmapped addresses
        wr(A_SW, 32'hFF);
        wr(A_LEVEL, 32'hFF);
        wr(32'h010, 32'hFF);
        wr(32'h020, 32'hFF);
        wr(32'h100, 32'hFF);
        rd("ro_edge", A_EDGE, 32'hA);
        rd("ro_count", A_COUNT, 32'h5);
        rd("ro_sw", A_SW, 32'h2A5);

        // Asynchronous reset mid-operation
        rd("pre_reset_count", A_COUNT, 32'h5);
        reset = 1'b0;
        #2;
        check("async_rd_clear", readdata_io, 32'h0);
        rd("mid_rst_level", A_LEVEL, 32'h0);
        reset = 1'b1;
        rd("post_rst_edge", A_EDGE, 32'h0);
        rd("post_rst_count", A_COUNT, 32'h0);
        rd("post_rst_level", A_LEVEL, 32'h0);

        // Key held through reset is re-debounced and counted once
        KEY = 4'h7;
        tick(4);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(HOLD);
        rd("held_level", A_LEVEL, 32'h8);
        rd("held_count", A_COUNT, 32'h1);
        KEY = 4'hF;
        tick(HOLD);
        wr(A_COUNT, 32'h0);

        // Counter wrap
        repeat (254) press(4'h1);
        rd("count_254", A_COUNT, 32'hFE);
        press(4'h5);
        rd("count_wrap", A_COUNT, 32'h0);
        rd("wrap_edge", 32'h130, 32'hD);
        press(4'h1);
        rd("count_1", A_COUNT, 32'h1);
        wr(A_COUNT, 32'h0);
        rd("count_write_clear", A_COUNT, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
